// File: rtl/lut_reduce_pkg.sv
// Op codes and helpers for the pipelined LUT reduction tree.
package lut_reduce_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2
    } op_e;

    localparam int MAX_WIDTH = 64;

    // Identity element used to pad an odd operand count at a tree level.
    function automatic logic op_identity(input int op);
        return (op == int'(OP_AND)) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic op_apply(input int op, input logic a, input logic b);
        logic r;
        case (op)
            int'(OP_AND): r = a & b;
            int'(OP_XOR): r = a ^ b;
            default:      r = a | b;
        endcase
        return r;
    endfunction

    // Operand count entering the given tree level (level 0 = the raw input word).
    function automatic int level_count(input int width, input int level);
        int n;
        n = width;
        for (int i = 0; i < level; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

endpackage

// File: rtl/lut_reduce_stage.sv
// One registered 2:1 level of the reduction tree; INV folds the final inversion into this register.
module lut_reduce_stage
    import lut_reduce_pkg::*;
#(
    parameter int   N_IN  = 2,
    parameter int   OP    = 0,
    parameter logic INV   = 1'b0,
    localparam int  N_OUT = (N_IN + 1) / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_i,
    input  logic [N_IN-1:0]  data_i,
    output logic             valid_o,
    output logic [N_OUT-1:0] data_o
);

    logic [2*N_OUT-1:0] padded;
    logic [N_OUT-1:0]   pairResult_d;
    logic [N_OUT-1:0]   pairResult_q;
    logic               valid_q;

    if (N_IN % 2 == 1) begin : g_pad
        assign padded = {op_identity(OP), data_i};
    end else begin : g_even
        assign padded = data_i;
    end

    always_comb begin
        pairResult_d = '0;
        for (int j = 0; j < N_OUT; j++) begin
            pairResult_d[j] = op_apply(OP, padded[2*j], padded[2*j+1]) ^ INV;
        end
    end

    // Data loads whenever the pipe advances; the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pairResult_q <= '0;
        end else if (en) begin
            valid_q      <= valid_i;
            pairResult_q <= pairResult_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = pairResult_q;

endmodule

// File: rtl/lut_reduce_pipe.sv
// Pipelined N-input OR/AND/XOR reduction with optional inversion and a global stall enable.
// Optional result-toggle counter built when LUT_REDUCE_TOGGLE_CNT_EN is defined.
module lut_reduce_pipe
    import lut_reduce_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int OP     = 0,
    parameter int INVERT = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic [CNT_W-1:0] tog_cnt
);

    localparam int L = $clog2(WIDTH);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("lut_reduce_pipe: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (OP < 0 || OP > 2) begin : g_bad_op
        $error("lut_reduce_pipe: illegal OP=%0d", OP);
    end

    logic             stall;
    logic             inValid_q;
    logic [WIDTH-1:0] inData_d;
    logic [WIDTH-1:0] inData_q;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // With no tree levels the input register is the output register, so it takes the inversion.
    assign inData_d = (L == 0 && INVERT != 0) ? ~in_data : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            inValid_q <= 1'b0;
            inData_q  <= '0;
        end else if (!stall) begin
            inValid_q <= in_valid;
            inData_q  <= inData_d;
        end
    end

    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int NIN  = level_count(WIDTH, l);
        localparam int NOUT = level_count(WIDTH, l + 1);

        logic [NIN-1:0]  stageIn;
        logic            stageValidIn;
        logic [NOUT-1:0] stageOut;
        logic            stageValidOut;

        if (l == 0) begin : g_first
            assign stageIn      = inData_q;
            assign stageValidIn = inValid_q;
        end else begin : g_next
            assign stageIn      = g_lvl[l-1].stageOut;
            assign stageValidIn = g_lvl[l-1].stageValidOut;
        end

        lut_reduce_stage #(
            .N_IN (NIN),
            .OP   (OP),
            .INV  ((l == L - 1) && (INVERT != 0))
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (~stall),
            .valid_i (stageValidIn),
            .data_i  (stageIn),
            .valid_o (stageValidOut),
            .data_o  (stageOut)
        );
    end

    if (L == 0) begin : g_no_tree
        assign out_valid = inValid_q;
        assign out_data  = inData_q[0];
    end else begin : g_tree
        assign out_valid = g_lvl[L-1].stageValidOut;
        assign out_data  = g_lvl[L-1].stageOut[0];
    end

`ifdef LUT_REDUCE_TOGGLE_CNT_EN
    logic             lastResult_q;
    logic             lastResult_d;
    logic [CNT_W-1:0] togCnt_q;
    logic [CNT_W-1:0] togCnt_d;

    // Count transferred results that differ from the previous transferred one; wraps naturally.
    always_comb begin
        lastResult_d = lastResult_q;
        togCnt_d     = togCnt_q;
        if (out_valid && out_ready) begin
            lastResult_d = out_data;
            if (out_data != lastResult_q) begin
                togCnt_d = togCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastResult_q <= 1'b0;
            togCnt_q     <= '0;
        end else begin
            lastResult_q <= lastResult_d;
            togCnt_q     <= togCnt_d;
        end
    end

    assign tog_cnt = togCnt_q;
`else
    assign tog_cnt = '0;
`endif

endmodule
